// File: rtl/scratchpad_stream.sv
// Result scratchpad: SP_NTARGETS matrix slots, registered operand-C readout and a
// valid/ready element stream. Define SP_ACCUM_EN to add wrap-around accumulating writes.

module scratchpad_stream_slot #(
    parameter int BUS_WIDTH = 64,
    parameter int ELEMS     = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       we_i,
`ifdef SP_ACCUM_EN
    input  logic                       accum_i,
`endif
    input  logic [BUS_WIDTH*ELEMS-1:0] wdata_i,
    output logic [BUS_WIDTH*ELEMS-1:0] q_o
);

    logic [ELEMS-1:0][BUS_WIDTH-1:0] q_q, wdata, d;

    assign wdata = wdata_i;
    assign q_o   = q_q;

    always_comb begin
        d = wdata;
`ifdef SP_ACCUM_EN
        if (accum_i) begin
            for (int k = 0; k < ELEMS; k++) d[k] = q_q[k] + wdata[k];
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   q_q <= '0;
        else if (we_i) q_q <= d;
    end

endmodule

module scratchpad_stream #(
    parameter  int DATA_WIDTH  = 16,
    parameter  int BUS_WIDTH   = 64,
    parameter  int SP_NTARGETS = 4,
    localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
    localparam int ELEMS       = MAX_DIM ** 2,
    localparam int TGT_W       = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1,
    localparam int IDX_W       = (ELEMS > 1) ? $clog2(ELEMS) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       wr_en_i,
    input  logic [TGT_W-1:0]           wr_target_i,
`ifdef SP_ACCUM_EN
    input  logic                       wr_accum_i,
`endif
    input  logic [BUS_WIDTH*ELEMS-1:0] res_i,
    input  logic                       rdc_en_i,
    input  logic [TGT_W-1:0]           rdc_target_i,
    output logic [BUS_WIDTH*ELEMS-1:0] operand_c_o,
    output logic                       operand_c_valid_o,
    input  logic                       strm_start_i,
    input  logic [TGT_W-1:0]           strm_target_i,
    output logic [BUS_WIDTH-1:0]       strm_data_o,
    output logic [IDX_W-1:0]           strm_index_o,
    output logic                       strm_valid_o,
    input  logic                       strm_ready_i,
    output logic                       strm_last_o,
    output logic                       strm_busy_o,
    output logic [SP_NTARGETS-1:0]     slot_valid_o,
    output logic                       err_o
);

    localparam int               NSLOT_P2 = 2 ** TGT_W;
    localparam logic [TGT_W:0]   NT       = (TGT_W + 1)'(SP_NTARGETS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS - 1);

    typedef enum logic {S_IDLE, S_STREAM} state_e;

    state_e                  state_q, state_d;
    logic [TGT_W-1:0]        strm_tgt_q, strm_tgt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    // Padded to the full target-select range; unbuilt slots read as zero.
    logic [NSLOT_P2-1:0][ELEMS-1:0][BUS_WIDTH-1:0] slot_rd;
    logic [SP_NTARGETS-1:0]  slot_we, slot_valid_q;
    logic [BUS_WIDTH*ELEMS-1:0] operand_c_q;
    logic                    operand_c_valid_q, err_q, err_d;

    logic wr_legal, rdc_legal, strm_legal, wr_conflict, wr_accept, streaming;

    assign wr_legal    = {1'b0, wr_target_i} < NT;
    assign rdc_legal   = {1'b0, rdc_target_i} < NT;
    assign strm_legal  = {1'b0, strm_target_i} < NT;
    assign streaming   = (state_q == S_STREAM);
    // The slot under readout is frozen so the consumer sees one consistent matrix.
    assign wr_conflict = streaming && (wr_target_i == strm_tgt_q);
    assign wr_accept   = wr_en_i && wr_legal && !wr_conflict;

    for (genvar n = 0; n < NSLOT_P2; n++) begin : g_slot
        if (n < SP_NTARGETS) begin : g_real
            assign slot_we[n] = wr_accept && (wr_target_i == TGT_W'(n));
            scratchpad_stream_slot #(
                .BUS_WIDTH(BUS_WIDTH),
                .ELEMS    (ELEMS)
            ) u_slot (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .we_i   (slot_we[n]),
`ifdef SP_ACCUM_EN
                .accum_i(wr_accum_i),
`endif
                .wdata_i(res_i),
                .q_o    (slot_rd[n])
            );
        end else begin : g_pad
            assign slot_rd[n] = '0;
        end
    end

    assign err_d = (wr_en_i && !(wr_legal && !wr_conflict))
                 | (rdc_en_i && !rdc_legal)
                 | (!streaming && strm_start_i && !strm_legal);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            operand_c_q       <= '0;
            operand_c_valid_q <= 1'b0;
            slot_valid_q      <= '0;
            err_q             <= 1'b0;
        end else begin
            // Slot flops update on this same edge, so the read sees old contents.
            if (rdc_en_i) operand_c_q <= rdc_legal ? slot_rd[rdc_target_i] : '0;
            operand_c_valid_q <= rdc_en_i;
            slot_valid_q      <= slot_valid_q | slot_we;
            err_q             <= err_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            strm_tgt_q <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            strm_tgt_q <= strm_tgt_d;
            idx_q      <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        strm_tgt_d = strm_tgt_q;
        idx_d      = idx_q;
        case (state_q)
            S_IDLE: begin
                if (strm_start_i && strm_legal) begin
                    state_d    = S_STREAM;
                    strm_tgt_d = strm_target_i;
                    idx_d      = '0;
                end
            end
            S_STREAM: begin
                if (strm_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign strm_valid_o      = streaming;
    assign strm_busy_o       = streaming;
    assign strm_last_o       = streaming && (idx_q == LAST_IDX);
    assign strm_index_o      = idx_q;
    assign strm_data_o       = streaming ? slot_rd[strm_tgt_q][idx_q] : '0;
    assign operand_c_o       = operand_c_q;
    assign operand_c_valid_o = operand_c_valid_q;
    assign slot_valid_o      = slot_valid_q;
    assign err_o             = err_q;

endmodule

// File: tb/tb_scratchpad_stream.sv
// Bench for scratchpad_stream: directed table, corner sequences and random traffic
// checked each cycle against a slot/stream reference model.

module tb_scratchpad_stream;

    localparam int DW = 16, BW = 64, NT = 3, ELEMS = 16, TW = 2, IW = 4;

    logic clk_i = 1'b0, rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic              wr_en_i, wr_accum_i, rdc_en_i, strm_start_i, strm_ready_i;
    logic [TW-1:0]     wr_target_i, rdc_target_i, strm_target_i;
    logic [BW*ELEMS-1:0] res_i, operand_c_o;
    logic              operand_c_valid_o, strm_valid_o, strm_last_o, strm_busy_o, err_o;
    logic [BW-1:0]     strm_data_o;
    logic [IW-1:0]     strm_index_o;
    logic [NT-1:0]     slot_valid_o;

    scratchpad_stream #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .SP_NTARGETS(NT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(wr_en_i), .wr_target_i(wr_target_i),
`ifdef SP_ACCUM_EN
        .wr_accum_i(wr_accum_i),
`endif
        .res_i(res_i), .rdc_en_i(rdc_en_i), .rdc_target_i(rdc_target_i),
        .operand_c_o(operand_c_o), .operand_c_valid_o(operand_c_valid_o),
        .strm_start_i(strm_start_i), .strm_target_i(strm_target_i),
        .strm_data_o(strm_data_o), .strm_index_o(strm_index_o), .strm_valid_o(strm_valid_o),
        .strm_ready_i(strm_ready_i), .strm_last_o(strm_last_o), .strm_busy_o(strm_busy_o),
        .slot_valid_o(slot_valid_o), .err_o(err_o)
    );

    int n_chk = 0, n_pass = 0;

    // Reference model: slot matrices, valid bits, operand C and stream position.
    logic [BW-1:0] m_mem [NT][ELEMS];
    logic [BW-1:0] m_opc [ELEMS];
    logic [NT-1:0] m_sv;
    logic          m_cv, m_err, m_busy;
    int            m_tgt, m_idx;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [BW-1:0] opc_el(input int k);
        return operand_c_o[k*BW +: BW];
    endfunction

    task automatic m_reset();
        for (int s = 0; s < NT; s++) for (int k = 0; k < ELEMS; k++) m_mem[s][k] = '0;
        for (int k = 0; k < ELEMS; k++) m_opc[k] = '0;
        m_sv = '0; m_cv = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_tgt = 0; m_idx = 0;
    endtask

    task automatic model_step();
        logic e, wr_bad, acc;
        int   wt, rt, st;
        e  = 1'b0;
        acc = 1'b0;
`ifdef SP_ACCUM_EN
        acc = wr_accum_i;
`endif
        wt = int'(wr_target_i); rt = int'(rdc_target_i); st = int'(strm_target_i);
        wr_bad = (wt >= NT) || (m_busy && wt == m_tgt);
        m_cv = rdc_en_i;
        if (rdc_en_i) begin
            for (int k = 0; k < ELEMS; k++) begin
                if (rt < NT) m_opc[k] = m_mem[rt][k];
                else         m_opc[k] = '0;
            end
            if (rt >= NT) e = 1'b1;
        end
        if (wr_en_i) begin
            if (wr_bad) e = 1'b1;
            else begin
                for (int k = 0; k < ELEMS; k++)
                    m_mem[wt][k] = acc ? m_mem[wt][k] + res_i[k*BW +: BW] : res_i[k*BW +: BW];
                m_sv[wt] = 1'b1;
            end
        end
        if (!m_busy) begin
            if (strm_start_i) begin
                if (st < NT) begin m_busy = 1'b1; m_tgt = st; m_idx = 0; end
                else e = 1'b1;
            end
        end else if (strm_ready_i) begin
            if (m_idx == ELEMS - 1) begin m_busy = 1'b0; m_idx = 0; end
            else m_idx++;
        end
        m_err = e;
    endtask

    task automatic check_model();
        int bad;
        bad = -1;
        chk("err", 64'(err_o), 64'(m_err));
        chk("opc_valid", 64'(operand_c_valid_o), 64'(m_cv));
        chk("slot_valid", 64'(slot_valid_o), 64'(m_sv));
        chk("busy", 64'(strm_busy_o), 64'(m_busy));
        chk("strm_valid", 64'(strm_valid_o), 64'(m_busy));
        chk("strm_index", 64'(strm_index_o), 64'(m_idx));
        chk("strm_last", 64'(strm_last_o), 64'(m_busy && m_idx == ELEMS - 1));
        chk("strm_data", strm_data_o, m_busy ? m_mem[m_tgt][m_idx] : 64'h0);
        for (int k = 0; k < ELEMS; k++) if (bad < 0 && opc_el(k) !== m_opc[k]) bad = k;
        if (bad < 0) bad = 0;
        chk($sformatf("operand_c[%0d]", bad), opc_el(bad), m_opc[bad]);
    endtask

    task automatic clr_in();
        wr_en_i = 0; wr_accum_i = 0; rdc_en_i = 0; strm_start_i = 0; strm_ready_i = 0;
        wr_target_i = '0; rdc_target_i = '0; strm_target_i = '0; res_i = '0;
    endtask

    task automatic set_res(input logic kp1, input logic [63:0] fill);
        for (int k = 0; k < ELEMS; k++) res_i[k*BW +: BW] = kp1 ? 64'(k + 1) : fill;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        model_step();
        #1;
        check_model();
    endtask

    typedef struct {
        logic wr; logic [1:0] wt; logic kp1; logic [63:0] fill;
        logic rd; logic [1:0] rt; logic st; logic [1:0] stt;
        logic e_err; logic [2:0] e_sv; logic e_cv; logic [63:0] e_e0, e_e15;
    } vec_t;
    vec_t tbl [13];

    initial begin
        tbl[0]  = '{1'b1, 2'd2, 1'b1, 64'h0,  1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 3'b100, 1'b0, 64'h0,  64'h0};
        tbl[1]  = '{1'b0, 2'd0, 1'b0, 64'h0,  1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 3'b100, 1'b1, 64'd1,  64'd16};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 64'h0,  1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 3'b100, 1'b0, 64'd1,  64'd16};
        tbl[3]  = '{1'b1, 2'd1, 1'b0, 64'h55, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 3'b110, 1'b0, 64'd1,  64'd16};
        tbl[4]  = '{1'b1, 2'd1, 1'b0, 64'hAA, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 3'b110, 1'b1, 64'h55, 64'h55};
        tbl[5]  = '{1'b0, 2'd0, 1'b0, 64'h0,  1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 3'b110, 1'b1, 64'hAA, 64'hAA};
        tbl[6]  = '{1'b1, 2'd3, 1'b0, 64'h77, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 3'b110, 1'b0, 64'hAA, 64'hAA};
        tbl[7]  = '{1'b0, 2'd0, 1'b0, 64'h0,  1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 3'b110, 1'b0, 64'hAA, 64'hAA};
        tbl[8]  = '{1'b0, 2'd0, 1'b0, 64'h0,  1'b1, 2'd3, 1'b0, 2'd0, 1'b1, 3'b110, 1'b1, 64'h0,  64'h0};
        tbl[9]  = '{1'b0, 2'd0, 1'b0, 64'h0,  1'b0, 2'd0, 1'b1, 2'd3, 1'b1, 3'b110, 1'b0, 64'h0,  64'h0};
        tbl[10] = '{1'b0, 2'd0, 1'b0, 64'h0,  1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 3'b110, 1'b1, 64'h0,  64'h0};
        tbl[11] = '{1'b1, 2'd3, 1'b0, 64'h77, 1'b1, 2'd3, 1'b1, 2'd3, 1'b1, 3'b110, 1'b1, 64'h0,  64'h0};
        tbl[12] = '{1'b0, 2'd0, 1'b0, 64'h0,  1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 3'b110, 1'b0, 64'h0,  64'h0};

        clr_in();
        m_reset();
        repeat (2) @(posedge clk_i);
        #1 check_model();
        @(negedge clk_i) rst_ni = 1'b1;

        // Directed table: write/read ordering, out-of-range targets, merged errors.
        for (int i = 0; i < 13; i++) begin
            clr_in();
            wr_en_i = tbl[i].wr; wr_target_i = tbl[i].wt; set_res(tbl[i].kp1, tbl[i].fill);
            rdc_en_i = tbl[i].rd; rdc_target_i = tbl[i].rt;
            strm_start_i = tbl[i].st; strm_target_i = tbl[i].stt;
            cyc();
            chk($sformatf("tbl%0d_err", i), 64'(err_o), 64'(tbl[i].e_err));
            chk($sformatf("tbl%0d_sv", i), 64'(slot_valid_o), 64'(tbl[i].e_sv));
            chk($sformatf("tbl%0d_cv", i), 64'(operand_c_valid_o), 64'(tbl[i].e_cv));
            chk($sformatf("tbl%0d_e0", i), opc_el(0), tbl[i].e_e0);
            chk($sformatf("tbl%0d_e15", i), opc_el(15), tbl[i].e_e15);
        end

        // Stream slot 2 with a stall at index 5 and conflicting write.
        clr_in();
        strm_start_i = 1; strm_target_i = 2'd2;
        cyc();
        chk("st_busy", 64'(strm_busy_o), 64'd1);
        chk("st_data0", strm_data_o, 64'd1);
        strm_start_i = 0; strm_ready_i = 1;
        repeat (5) cyc();
        strm_ready_i = 0;
        wr_en_i = 1; wr_target_i = 2'd2; set_res(1'b0, 64'h99);
        cyc();
        chk("conf_err", 64'(err_o), 64'd1);
        chk("stall_data_a", strm_data_o, 64'd6);
        wr_target_i = 2'd0; set_res(1'b0, 64'h33);
        cyc();
        chk("conf_err_once", 64'(err_o), 64'd0);
        chk("stall_idx_b", 64'(strm_index_o), 64'd5);
        chk("stall_sv", 64'(slot_valid_o), 64'b111);
        clr_in();
        cyc();
        chk("stall_data_c", strm_data_o, 64'd6);
        chk("stall_idx_c", 64'(strm_index_o), 64'd5);
        strm_ready_i = 1;
        for (int h = 5; h < ELEMS; h++) begin
            chk($sformatf("last_at_%0d", h), 64'(strm_last_o), 64'(h == ELEMS - 1));
            chk($sformatf("data_at_%0d", h), strm_data_o, 64'(h + 1));
            cyc();
        end
        chk("end_busy", 64'(strm_busy_o), 64'd0);
        chk("end_idx", 64'(strm_index_o), 64'd0);
        clr_in();
        rdc_en_i = 1; rdc_target_i = 2'd2;
        cyc();
        chk("slot2_kept", opc_el(7), 64'd8);
        rdc_target_i = 2'd0;
        cyc();
        chk("slot0_written", opc_el(7), 64'h33);

`ifdef SP_ACCUM_EN
        clr_in();
        wr_en_i = 1; wr_target_i = 2'd0; set_res(1'b0, 64'd7);
        cyc();
        wr_accum_i = 1; set_res(1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
        cyc();
        clr_in();
        rdc_en_i = 1; rdc_target_i = 2'd0;
        cyc();
        chk("accum_e0", opc_el(0), 64'd5);
        chk("accum_e15", opc_el(15), 64'd5);
`endif

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            wr_en_i = 1'($urandom_range(0, 1));
            wr_accum_i = 1'($urandom_range(0, 1));
            wr_target_i = 2'($urandom_range(0, 3));
            for (int k = 0; k < ELEMS; k++) res_i[k*BW +: BW] = {$urandom, $urandom};
            rdc_en_i = 1'($urandom_range(0, 1));
            rdc_target_i = 2'($urandom_range(0, 3));
            strm_start_i = ($urandom_range(0, 3) == 0);
            strm_target_i = 2'($urandom_range(0, 3));
            strm_ready_i = ($urandom_range(0, 3) != 0);
            cyc();
        end

        // Asynchronous reset in the middle of a stream.
        clr_in();
        wr_en_i = 1; wr_target_i = 2'd1; set_res(1'b0, 64'h1234);
        cyc();
        clr_in();
        strm_start_i = 1; strm_target_i = 2'd1; strm_ready_i = 1;
        if (m_busy) begin
            strm_start_i = 0;
            for (int g = 0; g < 40 && m_busy; g++) cyc();
            strm_start_i = 1;
        end
        cyc();
        strm_start_i = 0;
        cyc();
        chk("pre_rst_busy", 64'(strm_busy_o), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        m_reset();
        chk("rst_busy", 64'(strm_busy_o), 64'd0);
        chk("rst_valid", 64'(strm_valid_o), 64'd0);
        chk("rst_last", 64'(strm_last_o), 64'd0);
        chk("rst_idx", 64'(strm_index_o), 64'd0);
        chk("rst_data", strm_data_o, 64'd0);
        chk("rst_sv", 64'(slot_valid_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_cv", 64'(operand_c_valid_o), 64'd0);
        chk("rst_opc", 64'(|operand_c_o), 64'd0);
        @(negedge clk_i) rst_ni = 1'b1;
        clr_in();
        rdc_en_i = 1; rdc_target_i = 2'd1;
        cyc();
        chk("rst_slot_cleared", opc_el(3), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/scratchpad_stream.md
Name: scratchpad_stream

Overview:
- Next-generation result scratchpad for the systolic-array matrix accelerator. Holds SP_NTARGETS full result matrices from the adder stage.
- Serves two consumers:
  - a registered bulk read of operand C back into the array datapath;
  - a valid/ready element stream toward the memory decoder.
- Generalises the target count to any value 1..16 and adds per-slot valid tracking, a handshaked readout FSM, and write/stream conflict protection.

Parameters:
- DATA_WIDTH, 16, width of one matrix datum in bits.
- BUS_WIDTH, 64, width of one stored element (bus word) in bits.
- SP_NTARGETS, 4, number of matrix slots, legal range 1..16.
- MAX_DIM (localparam), BUS_WIDTH/DATA_WIDTH, matrix dimension.
- ELEMS (localparam), MAX_DIM**2, elements per matrix.
- TGT_W (localparam), max(1,$clog2(SP_NTARGETS)), target select width.
- IDX_W (localparam), max(1,$clog2(ELEMS)), element index width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- wr_en_i  in  1  write full matrix res_i into slot wr_target_i.
- wr_target_i  in  TGT_W  write slot.
- res_i  in  BUS_WIDTH*ELEMS  adder result; element k at bits [BUS_WIDTH*(k+1)-1 -: BUS_WIDTH].
- rdc_en_i  in  1  load operand_c_o from slot rdc_target_i.
- rdc_target_i  in  TGT_W  operand C slot.
- operand_c_o  out  BUS_WIDTH*ELEMS  registered matrix C, same packing as res_i.
- operand_c_valid_o  out  1  one-cycle pulse when operand_c_o was updated.
- strm_start_i  in  1  start streaming slot strm_target_i.
- strm_target_i  in  TGT_W  stream slot.
- strm_data_o  out  BUS_WIDTH  current stream element.
- strm_index_o  out  IDX_W  index of current element.
- strm_valid_o  out  1  element valid.
- strm_ready_i  in  1  consumer accepts element.
- strm_last_o  out  1  current element is index ELEMS-1.
- strm_busy_o  out  1  FSM not IDLE.
- slot_valid_o  out  SP_NTARGETS  bit n set once slot n has been written.
- err_o  out  1  one-cycle pulse on any rejected request.

Behaviour:
- Reset (async):
  - all slot contents, operand_c_o, slot_valid_o and strm_index_o are 0;
  - operand_c_valid_o and err_o are 0;
  - FSM is IDLE, so strm_valid_o, strm_last_o and strm_busy_o are 0 and strm_data_o is 0.
- Write:
  - When wr_en_i is high and wr_target_i < SP_NTARGETS, all ELEMS elements are stored at the next edge and slot_valid_o[target] is set.
  - wr_target_i >= SP_NTARGETS: write ignored, err_o pulses.
- Operand C read:
  - rdc_en_i captures the slot into operand_c_o at the next edge (1-cycle latency), and operand_c_valid_o pulses the same cycle operand_c_o changes.
  - Read and write of the same slot in the same cycle returns the OLD contents.
  - Out-of-range target: operand_c_o is loaded with 0 and err_o pulses.
  - Reading a slot whose slot_valid_o bit is clear returns the stored zeros, with no error.
  - operand_c_o holds its value when rdc_en_i is low.
- Stream FSM, IDLE:
  - strm_start_i with a legal target latches the target, sets index 0 and moves to STREAM next cycle.
  - strm_start_i with an illegal target stays in IDLE and pulses err_o.
- Stream FSM, STREAM:
  - strm_valid_o = 1 and strm_data_o = slot[latched target][strm_index_o] (combinational from array).
  - strm_last_o = (strm_index_o == ELEMS-1).
  - On strm_valid_o && strm_ready_i the index increments.
  - Handshake on the last element: return to IDLE next cycle; strm_valid_o and strm_last_o drop and strm_index_o returns to 0.
  - ready low stalls: data and index are held stable.
  - strm_start_i while in STREAM is ignored (no error).
- Conflict: a write to the slot currently being streamed (FSM in STREAM) is dropped, err_o pulses, and slot contents and slot_valid_o are unchanged. Writes to other slots proceed.
- Simultaneous events:
  - a write, an operand C read and stream progress may all occur in one cycle;
  - multiple error causes in one cycle yield a single err_o pulse.
- SP_NTARGETS = 1: target ports are 1 bit wide and value 1 is out of range.
- Reset mid-stream aborts to IDLE immediately; all slots are cleared.

Optional Feature:
- Macro: SP_ACCUM_EN.
- Defined:
  - adds input port wr_accum_i (1 bit);
  - when wr_accum_i is high with an accepted write, each element is stored as old + new, a BUS_WIDTH-bit wrap-around add, in one cycle;
  - when wr_accum_i is low, the write overwrites the slot;
  - slot_valid_o behaves as for an ordinary write;
  - conflict and range rules are unchanged.
- Not defined: the port is absent and every write overwrites.

Test Plan:
- Reset, then write slot 2 with element k = k+1 (k=0..15), then rdc_en_i with target 2 -> one cycle later operand_c_o element k = k+1, operand_c_valid_o is a single pulse, slot_valid_o = 4'b0100.
- Same-cycle write of slot 1 (all elements 0xAA) and rdc_en_i on slot 1 holding all 0x55 -> operand_c_o = all 0x55; the next read returns 0xAA.
- Stream slot 2 with strm_ready_i low for 3 cycles at index 5 -> data = 6 held, index = 5 held; then ready high -> 16 handshakes, strm_last_o on index 15, strm_busy_o drops the following cycle.
- During the stream of slot 2, write slot 2 and slot 0 -> slot 2 unchanged, err_o pulses once, slot 0 updated.
- wr_target_i = 5 with SP_NTARGETS = 4 (TGT_W = 2, so drive target 3 with SP_NTARGETS = 3 instead) -> no state change, err_o pulses for one cycle.
- SP_ACCUM_EN defined: write slot 0 with all 7, then accumulate all 0xFFFF_FFFF_FFFF_FFFE -> every element = 5 (wrap-around); rst_ni asserted mid-stream -> all outputs 0, FSM in IDLE.
